// File: rtl/mux16_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux16_rr_arbiter
// Purpose  : Round-robin arbiter/sequencer for a 16:1 datapath mux. Holds a
//            grant for a whole burst (until the beat flagged last) and
//            registers every accepted beat into a single-entry output stage.
// Revision : 1.0 - initial release
// ============================================================================
module mux16_rr_arbiter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [15:0]           req_valid,
  input  logic [15:0]           req_last,
  output logic [15:0]           req_ready,
  output logic [3:0]            mux_sel,
  input  logic [DATA_WIDTH-1:0] mux_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic [3:0]            out_src,
  output logic                  busy
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            ptr_q, ptr_d;
  logic [3:0]            grant_q, grant_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_last_q, out_last_d;
  logic [3:0]            out_src_q, out_src_d;

  logic                  win_found;
  logic [3:0]            win_idx;
  logic [3:0]            cand;
  logic                  space;
  logic                  xfer;

  // Rotating priority search: first requester at or above ptr, wrapping 15->0.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    cand      = '0;
    for (int i = 0; i < 16; i++) begin
      cand = ptr_q + i[3:0];
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Output stage can take a beat when empty or draining this cycle.
  assign space = ~out_valid_q | out_ready;
  assign xfer  = (state_q == LOCKED) & req_valid[grant_q] & space;

  // Only the granted requester ever sees ready, and only while locked.
  always_comb begin
    req_ready = '0;
    if (state_q == LOCKED) begin
      req_ready[grant_q] = space;
    end
  end

  // Next-state logic: arbitrate in IDLE, release after the last beat moves.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          grant_d = win_idx;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (xfer && req_last[grant_q]) begin
          state_d = IDLE;
          ptr_d   = grant_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output register: reload on transfer, otherwise clear once drained.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_src_d   = out_src_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = mux_data;
      out_last_d  = req_last[grant_q];
      out_src_d   = grant_q;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      grant_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_src_q   <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_src_q   <= out_src_d;
    end
  end

  // The select follows the grant, which holds its value while idle.
  assign mux_sel   = grant_q;
  assign busy      = (state_q == LOCKED);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_src   = out_src_q;

endmodule
`default_nettype wire

// File: tb/tb_mux16_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux16_rr_arbiter
// Purpose  : Directed, scoreboard-based bench for mux16_rr_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux16_rr_arbiter;

  logic        clk;
  logic        rst;
  logic [15:0] req_valid;
  logic [15:0] req_last;
  logic [15:0] req_ready;
  logic [3:0]  mux_sel;
  logic [31:0] mux_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic [3:0]  out_src;
  logic        busy;

  mux16_rr_arbiter #(.DATA_WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_ready (req_ready),
    .mux_sel   (mux_sel),
    .mux_data  (mux_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_src   (out_src),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Per-requester beat FIFOs: main process writes, driver process reads.
  bit [32:0]   mem [16][16];
  int          rd  [16];
  int          wr  [16];
  logic [15:0] stall;
  logic [15:0] hv;
  logic [15:0] hl;
  logic [31:0] hd  [16];
  logic [15:0] acc;

  logic [36:0] exp_q [$];
  int          n_vec;
  int          n_err;

  always_comb begin
    for (int i = 0; i < 16; i++) begin
      hv[i] = (rd[i] != wr[i]);
      hl[i] = mem[i][rd[i] % 16][32];
      hd[i] = mem[i][rd[i] % 16][31:0];
    end
  end

  assign req_valid = hv & ~stall;
  assign req_last  = hl;
  assign mux_data  = hd[mux_sel];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int r, input logic [31:0] d, input bit last);
    mem[r][wr[r] % 16] = {last, d};
    wr[r]++;
  endtask

  task automatic expect_beat(input logic [3:0] src, input logic [31:0] d, input bit last);
    exp_q.push_back({src, last, d});
  endtask

  task automatic do_reset;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, ".out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, ".out_data"},  64'(out_data),  64'd0);
    chk({tag, ".out_last"},  64'(out_last),  64'd0);
    chk({tag, ".out_src"},   64'(out_src),   64'd0);
    chk({tag, ".busy"},      64'(busy),      64'd0);
    chk({tag, ".mux_sel"},   64'(mux_sel),   64'd0);
    chk({tag, ".req_ready"}, 64'(req_ready), 64'd0);
  endtask

  // Waits until every queue, the output stage and the grant are empty.
  task automatic drain(input string tag);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid && !busy && hv == 16'h0) begin
        done = 1'b1;
        break;
      end
    end
    chk({tag, ".drain_done"}, 64'(done), 64'd1);
    chk({tag, ".exp_left"}, 64'(exp_q.size()), 64'd0);
    tick();
  endtask

  // Requester model: pop a beat after every accepted handshake.
  initial begin
    acc = '0;
    forever begin
      @(negedge clk);
      acc = rst ? 16'h0 : (req_valid & req_ready);
      @(posedge clk);
      #1;
      for (int i = 0; i < 16; i++) begin
        if (acc[i]) rd[i]++;
      end
    end
  end

  // Monitor: compare every beat leaving the output stage with the scoreboard.
  initial begin
    logic [36:0] e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_beat: got src=%0d last=%0d data=%h expected none",
                   out_src, out_last, out_data);
        end else begin
          e = exp_q.pop_front();
          chk("beat{src,last,data}", 64'({out_src, out_last, out_data}), 64'(e));
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t expected finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec     = 0;
    n_err     = 0;
    rst       = 1'b1;
    out_ready = 1'b0;
    stall     = '0;

    // 1. Reset then idle
    repeat (2) tick();
    rst = 1'b0;
    @(negedge clk);
    check_idle("t1.after_reset");
    repeat (10) tick();
    @(negedge clk);
    check_idle("t1.idle10");

    // 2. Single burst from requester 5
    tick();
    out_ready = 1'b1;
    push(5, 32'hA0, 1'b0); expect_beat(4'd5, 32'hA0, 1'b0);
    push(5, 32'hA1, 1'b0); expect_beat(4'd5, 32'hA1, 1'b0);
    push(5, 32'hA2, 1'b1); expect_beat(4'd5, 32'hA2, 1'b1);
    @(negedge clk);
    chk("t2.busy_N", 64'(busy), 64'd0);
    tick();
    @(negedge clk);
    chk("t2.mux_sel_N1",   64'(mux_sel),   64'd5);
    chk("t2.busy_N1",      64'(busy),      64'd1);
    chk("t2.req_ready_N1", 64'(req_ready), 64'h0020);
    tick();
    @(negedge clk);
    chk("t2.out_valid_N2", 64'(out_valid), 64'd1);
    chk("t2.out_src_N2",   64'(out_src),   64'd5);
    drain("t2");
    // ptr is now 6: requester 7 must beat requester 4
    push(4, 32'h40, 1'b1);
    push(7, 32'h70, 1'b1);
    expect_beat(4'd7, 32'h70, 1'b1);
    expect_beat(4'd4, 32'h40, 1'b1);
    drain("t2.ptr6");

    // 3. Round robin with wrap from a fresh pointer
    do_reset();
    push(0, 32'h00, 1'b1);
    push(0, 32'h01, 1'b1);
    push(1, 32'h10, 1'b1);
    push(1, 32'h11, 1'b1);
    push(15, 32'hF0, 1'b1);
    expect_beat(4'd0,  32'h00, 1'b1);
    expect_beat(4'd1,  32'h10, 1'b1);
    expect_beat(4'd15, 32'hF0, 1'b1);
    expect_beat(4'd0,  32'h01, 1'b1);
    expect_beat(4'd1,  32'h11, 1'b1);
    drain("t3");

    // 4. Backpressure mid-burst on requester 3
    push(3, 32'h30, 1'b0); expect_beat(4'd3, 32'h30, 1'b0);
    push(3, 32'h31, 1'b0); expect_beat(4'd3, 32'h31, 1'b0);
    push(3, 32'h32, 1'b0); expect_beat(4'd3, 32'h32, 1'b0);
    push(3, 32'h33, 1'b1); expect_beat(4'd3, 32'h33, 1'b1);
    tick();
    tick();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t4.req_ready_held", 64'(req_ready), 64'h0);
      chk("t4.out_valid_held", 64'(out_valid), 64'd1);
      chk("t4.out_data_held",  64'(out_data),  64'h30);
      tick();
    end
    out_ready = 1'b1;
    drain("t4");

    // 5. Bubble lock: requester 2 stalls while requester 7 waits
    push(2, 32'h20, 1'b0); expect_beat(4'd2, 32'h20, 1'b0);
    push(2, 32'h21, 1'b0); expect_beat(4'd2, 32'h21, 1'b0);
    push(2, 32'h22, 1'b1); expect_beat(4'd2, 32'h22, 1'b1);
    tick();
    tick();
    stall[2] = 1'b1;
    push(7, 32'h77, 1'b1); expect_beat(4'd7, 32'h77, 1'b1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("t5.stall_busy",      64'(busy),      64'd1);
      chk("t5.stall_mux_sel",   64'(mux_sel),   64'd2);
      chk("t5.stall_req_ready", 64'(req_ready), 64'h0004);
      tick();
    end
    stall[2] = 1'b0;
    begin
      bit released;
      released = 1'b0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (!busy) begin
          released = 1'b1;
          break;
        end
        chk("t5.req_ready7_blocked", 64'(req_ready[7]), 64'd0);
        tick();
      end
      chk("t5.released", 64'(released), 64'd1);
    end
    chk("t5.idle_req_ready", 64'(req_ready), 64'h0);
    tick();
    @(negedge clk);
    chk("t5.grant7_mux_sel", 64'(mux_sel), 64'd7);
    chk("t5.grant7_busy",    64'(busy),    64'd1);
    drain("t5");

    // 6. Reset mid-burst on requester 9 with a beat held in the output stage
    out_ready = 1'b0;
    push(9, 32'h90, 1'b0);
    push(9, 32'h91, 1'b0);
    push(9, 32'h92, 1'b0);
    push(9, 32'h93, 1'b1);
    tick();
    tick();
    @(negedge clk);
    chk("t6.pre_out_valid", 64'(out_valid), 64'd1);
    chk("t6.pre_busy",      64'(busy),      64'd1);
    chk("t6.pre_mux_sel",   64'(mux_sel),   64'd9);
    chk("t6.pre_out_data",  64'(out_data),  64'h90);
    tick();
    rst   = 1'b1;
    wr[9] = rd[9];
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t6.rst_out_valid", 64'(out_valid), 64'd0);
    chk("t6.rst_req_ready", 64'(req_ready), 64'h0);
    chk("t6.rst_busy",      64'(busy),      64'd0);
    chk("t6.rst_mux_sel",   64'(mux_sel),   64'd0);
    tick();
    out_ready = 1'b1;
    push(9, 32'h9A, 1'b1);
    push(3, 32'h3A, 1'b1);
    expect_beat(4'd3, 32'h3A, 1'b1);
    expect_beat(4'd9, 32'h9A, 1'b1);
    drain("t6");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
